// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, digit width and the saturation pattern builder.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DIGIT_W       = 4;
  localparam int MAX_DIGITS    = 32;
  localparam int BIN_W_DEFAULT = 24;

  // Iteration counter must be able to hold BIN_W itself.
  function automatic int counter_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  localparam int CNT_W_DEFAULT = counter_width(BIN_W_DEFAULT);

  // All-nines pattern for the lowest 'digits' digits; callers truncate to their width.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] nines(input int digits);
    logic [DIGIT_W*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) r[DIGIT_W*i +: DIGIT_W] = 4'h9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 over BIN_W cycles) with
// valid/ready on both sides. Define BIN2BCD_SIGNED_EN to honour signed_mode.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_W-1:0]       bin,
  input  logic                   signed_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                   neg,
  output logic                   ovf
);

  localparam int AW    = DIGIT_W * DIGITS;
  localparam int CNT_W = counter_width(BIN_W);
  localparam logic [AW-1:0] SAT = AW'(nines(DIGITS));

  state_t           state, state_nx;
  logic [BIN_W-1:0] mag, mag_load, mag_sh;
  logic [AW-1:0]    acc, adj, acc_sh;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r, ovf_sh, neg_r, neg_load;
  logic             accept, last;

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude is BIN_W unsigned, so the most negative operand negates exactly.
  assign neg_load = signed_mode & bin[BIN_W-1];
  assign mag_load = neg_load ? -bin : bin;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign neg_load = 1'b0;
  assign mag_load = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit   (acc[DIGIT_W*g +: DIGIT_W]),
      .adjusted(adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Bit shifted out of the top digit means the magnitude no longer fits.
  assign acc_sh = {adj[AW-2:0], mag[BIN_W-1]};
  assign mag_sh = {mag[BIN_W-2:0], 1'b0};
  assign ovf_sh = ovf_r | adj[AW-1];

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == SHIFT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag   <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      neg_r <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      mag   <= mag_load;
      neg_r <= neg_load;
      acc   <= '0;
      ovf_r <= 1'b0;
      cnt   <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      mag   <= mag_sh;
      acc   <= acc_sh;
      ovf_r <= ovf_sh;
      cnt   <= cnt - 1'b1;
      if (last) begin
        bcd <= ovf_sh ? SAT : acc_sh;
        neg <= neg_r;
        ovf <= ovf_sh;
      end
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter for the calculator display path. It uses shift-and-add-3 (double dabble) over BIN_W cycles instead of wide divide/modulo logic. A valid/ready handshake sits on both sides, and the block supports signed or unsigned operands. Over-range values produce a saturated result with an overflow flag. It sits between the ALU result register and the seven-segment digit driver.

## Interface
- BIN_W, 24, binary operand width (≥2)
- DIGITS, 6, BCD output digits (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand available
- in_ready  out  1  block can accept an operand
- bin  in  BIN_W  operand, sampled only on accept
- signed_mode  in  1  1 = bin is two's complement, 0 = unsigned; sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0]
- neg  out  1  operand was negative
- ovf  out  1  magnitude ≥ 10^DIGITS; bcd saturated

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: BIN_W iterations.
  - DONE: out_valid=1.
- IDLE→SHIFT on in_valid&&in_ready.
  - Magnitude register: loaded with −bin if signed_mode&&bin[BIN_W-1], else bin.
  - neg_r is set accordingly.
  - BCD accumulator and sticky ovf are cleared.
  - Iteration counter is loaded with BIN_W.
- SHIFT, per cycle:
  - Every accumulator digit ≥5 gets +3.
  - {acc, mag} is shifted left by 1.
  - The bit leaving acc[4*DIGITS-1] is ORed into sticky ovf.
  - The counter decrements; on the last iteration the state goes to DONE.
- DONE:
  - bcd = ovf ? all digits 9 : acc.
  - neg = neg_r, independent of ovf.
  - DONE→IDLE on out_ready.
- Magnitude width is BIN_W unsigned, so −2^(BIN_W-1) converts correctly (with BIN_W=24 it overflows 6 digits).
- Zero in signed mode gives neg=0.
- bin and signed_mode changing after accept have no effect.
- bcd/neg/ovf are registered and hold their last value until the next DONE entry.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, bcd=0, neg=0, ovf=0, counter=0.
- Accept edge E0. out_valid rises after edge E_BIN_W, i.e. BIN_W cycles after accept (24 by default).
- Throughput: one conversion per BIN_W+2 cycles minimum.
  - in_ready is 0 throughout SHIFT and DONE.
  - in_ready returns to 1 the cycle after the out_ready handshake.
- Backpressure: in DONE with out_ready=0, all outputs hold indefinitely and in_valid is ignored.
- out_ready outside DONE is ignored.
- Reset asserted mid-conversion: immediate return to reset values. The partial result is discarded and never presented.
- in_valid high on the reset-release cycle is accepted on the first edge after release.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - signed_mode is honoured as above.
- Undefined:
  - The negation logic is removed and signed_mode is ignored.
  - Every operand is unsigned and neg is constant 0.
  - Ports are identical in both builds.

## Structure
- Package bin2bcd_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - DIGIT_W=4
  - function nines(DIGITS) returning the saturation pattern
  - localparam for counter width $clog2(BIN_W+1)
- Sub-module bcd_digit_adj:
  - 4-bit combinational add-3-if-≥5.
  - Generate-instanced DIGITS times in the top.

## Test plan
- Defaults, BIN2BCD_SIGNED_EN on, signed_mode=1, bin=0x003039 → bcd=0x012345, neg=0, ovf=0. out_valid rises exactly 24 cycles after accept.
- signed_mode=1, bin=0xFFFFFF → bcd=0x000001, neg=1, ovf=0. With signed_mode=0, same bin=16777215 → bcd=0x999999, ovf=1, neg=0.
- Unsigned bin=0x0F423F (999999) → bcd=0x999999, ovf=0. Then bin=0x0F4240 (1000000) → bcd=0x999999, ovf=1.
- signed_mode=1, bin=0x800000 → neg=1, ovf=1, bcd=0x999999. Signed zero → bcd=0, neg=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/bin.
  - Outputs stay stable and in_ready stays 0.
  - On out_ready=1, in_ready=1 the next cycle.
  - The next operand converts correctly.
- Drop rst_n at iteration 12:
  - Outputs go to reset values asynchronously.
  - After release, bin=0x000064 converts to bcd=0x000100.
- Rebuild without the macro: signed_mode=1, bin=0xFFFFFF → bcd=0x999999, ovf=1, neg=0.
